crt_timing_gen: RTL and testbench
=================================

// Module: crt_timing_gen
// PURPOSE
//   Display timing initiator that drives the crt_ramdac pixel interface.
//   It generates hs, vs, ven and a linear framebuffer pixel address
//   (pixaddr) from free-running horizontal and vertical counters.
//   It sits upstream of the RAMDAC on the same clock; the RAMDAC fetches
//   from pixaddr while ven is high. Supports a double-buffer flip: a new
//   frame base is latched once per frame, during vsync.
// PARAMETERS
//   PIXADDR_WIDTH  32  width of pixaddr/fb_base; address arithmetic wraps mod 2^PIXADDR_WIDTH
//   H_VIS          640 visible pixels per line
//   H_FP           16  horizontal front porch, clocks
//   H_SYNC         96  hsync width, clocks
//   H_BP           48  horizontal back porch, clocks
//   V_VIS          480 visible lines per frame
//   V_FP           10  vertical front porch, lines
//   V_SYNC         2   vsync width, lines
//   V_BP           33  vertical back porch, lines
//   HS_POL         0   hs active level (0 = active-low)
//   VS_POL         0   vs active level (0 = active-low)
//   STRIDE         640 address increment between consecutive visible lines
//   RESET_BASE     0   frame base in use after reset
// PORTS
//   clk            in   1              pixel clock; all logic on rising edge
//   rst_n          in   1              asynchronous reset, active-low
//   fb_base        in   PIXADDR_WIDTH  next frame base; sampled at flip point
//   hs             out  1              horizontal sync, polarity HS_POL
//   vs             out  1              vertical sync, polarity VS_POL
//   ven            out  1              high for visible pixels
//   pixaddr        out  PIXADDR_WIDTH  address of current visible pixel
//   frame_start    out  1              1-cycle pulse at position (h=0, v=0)
//   flip_done      out  1              1-cycle pulse when fb_base is latched
// BEHAVIOUR
//   - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h counts 0..H_TOTAL-1;
//     v increments when h wraps and counts 0..V_TOTAL-1, then wraps to 0.
//   - Reset (async assert): h=v=0, frame base = RESET_BASE, line base = RESET_BASE.
//     Outputs: hs=~HS_POL, vs=~VS_POL, ven=0, pixaddr=0, frame_start=0, flip_done=0.
//     Reset mid-frame abandons the frame; counting restarts at (0,0).
//   - Position k = k-th clock edge after rst_n release (k=0 is the first edge, at (0,0)).
//     All outputs are registered: the value after edge k+1 reflects position k (1-cycle latency).
//   - ven = (h < H_VIS) && (v < V_VIS).
//   - hs active when H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC, on every line including vblank.
//   - vs active for all h while V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC.
//   - pixaddr while ven: line_base + h. line_base = frame base at v=0 and grows by
//     STRIDE at the end of each visible line. No multiplier is used.
//     Outside ven, pixaddr holds the last visible value.
//   - Flip: at position (h=0, v=V_VIS+V_FP), fb_base is latched as the frame base
//     for the next frame and flip_done pulses. fb_base changes at any other time
//     have no effect. Line base reloads from the frame base at position (0,0).
//   - frame_start pulses for position (0,0), coincident with the first ven of the frame.
//   - Address sums truncate to PIXADDR_WIDTH bits (wrap, no saturation).
//   - Legal parameters: every H_* and V_* value >= 1. Any other setting is unsupported.
// TESTING  (small timing: H 4/1/2/1 -> H_TOTAL=8; V 3/1/1/1 -> V_TOTAL=6; STRIDE=16;
//           RESET_BASE=0; HS_POL=VS_POL=0; frame = 48 clocks)
//   1 release reset, fb_base=0 -> ven high after edges 1-4, 9-12, 17-20;
//     pixaddr 0..3, 16..19, 32..35; ven low for all other edges up to 48.
//   2 same run -> hs low after edges 6-7 and 14-15 (every 8 clocks, including vblank);
//     vs low after edges 33-40; frame_start high only after edges 1, 49, 97.
//   3 fb_base=0x100 held from edge 0 -> flip_done after edge 33; after edges 49-52
//     pixaddr=0x100..0x103; after edges 57-60 pixaddr=0x110..0x113.
//   4 fb_base=0x200 during edges 0-31, changed to 0x300 only at edge 40 ->
//     second frame starts at 0x200; the 0x300 change is ignored until the next flip.
//   5 PIXADDR_WIDTH=32, fb_base=0xFFFFFFFE -> second frame first line
//     pixaddr=FFFFFFFE, FFFFFFFF, 00000000, 00000001; second line starts at 0x0000000E.
//   6 assert rst_n low at edge 20, release -> outputs at reset values immediately;
//     the next frame_start and ven follow edge 1 after release, with pixaddr=RESET_BASE.

Source files
------------

// File: rtl/crt_timing_gen_if.sv
// crt_timing_gen_if: pixel-timing bus from the timing generator to the RAMDAC.
interface crt_timing_gen_if #(parameter int PIXADDR_WIDTH = 32);
  logic [PIXADDR_WIDTH-1:0] fb_base;
  logic                     hs;
  logic                     vs;
  logic                     ven;
  logic [PIXADDR_WIDTH-1:0] pixaddr;
  logic                     frame_start;
  logic                     flip_done;
  modport master (input fb_base, output hs, vs, ven, pixaddr, frame_start, flip_done);
  modport slave (output fb_base, input hs, vs, ven, pixaddr, frame_start, flip_done);
endinterface

// File: rtl/crt_timing_gen.sv
// crt_timing_gen: hs/vs/ven and linear pixel address from free-running h/v counters,
// with a double-buffer frame base latched once per frame during vsync.
module crt_timing_gen #(
  parameter int PIXADDR_WIDTH = 32,
  parameter int H_VIS         = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_VIS         = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit HS_POL        = 1'b0,
  parameter bit VS_POL        = 1'b0,
  parameter int STRIDE        = 640,
  parameter int RESET_BASE    = 0
) (
  input logic             clk,
  input logic             rst_n,
  crt_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = PIXADDR_WIDTH;
  logic          run_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] fbase_q, fbase_d, lbase_q, lbase_d, pix_q, pix_d, lb;
  logic          hs_q, hs_d, vs_q, vs_d, ven_q, ven_d, fs_q, fs_d, fd_q, fd_d;
  logic          h_wrap, top;
  always_comb begin
    h_wrap  = h_q == HW'(H_TOTAL - 1);
    top     = h_q == '0 && v_q == '0;
    ven_d   = h_q < HW'(H_VIS) && v_q < VW'(V_VIS);
    fd_d    = h_q == '0 && v_q == VW'(V_VIS + V_FP);
    fs_d    = top;
    lb      = top ? fbase_q : lbase_q;
    h_d     = h_wrap ? '0 : h_q + HW'(1);
    v_d     = !h_wrap ? v_q : (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
    lbase_d = (ven_d && h_q == HW'(H_VIS - 1)) ? lb + AW'(STRIDE) : lb;
    fbase_d = fd_d ? bus.fb_base : fbase_q;
    pix_d   = ven_d ? lb + AW'(h_q) : pix_q;
    hs_d    = (h_q >= HW'(H_VIS + H_FP) && h_q < HW'(H_VIS + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    vs_d    = (v_q >= VW'(V_VIS + V_FP) && v_q < VW'(V_VIS + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
  end
  // The first edge after release only arms the pipeline so position k lands after edge k+1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fbase_q <= AW'(RESET_BASE);
      lbase_q <= AW'(RESET_BASE);
      pix_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      ven_q   <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      fbase_q <= fbase_d;
      lbase_q <= lbase_d;
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ven_q   <= ven_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.ven         = ven_q;
  assign bus.pixaddr     = pix_q;
  assign bus.frame_start = fs_q;
  assign bus.flip_done   = fd_q;
endmodule

// File: tb/tb_crt_timing_gen.sv
// tb_crt_timing_gen: randomized fb_base/reset stimulus against a position-based timing model.
module tb_crt_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [31:0] frame_reg = 32'h0;
  logic [31:0] cur_base = 32'h0;
  logic [31:0] last_pix = 32'h0;
  crt_timing_gen_if #(.PIXADDR_WIDTH(32)) bus ();
  crt_timing_gen #(
    .PIXADDR_WIDTH(32), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .STRIDE(16), .RESET_BASE(0)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  task automatic reset_chk();
    chk("rst_hs", 32'(bus.hs), 32'd1);
    chk("rst_vs", 32'(bus.vs), 32'd1);
    chk("rst_ven", 32'(bus.ven), 32'd0);
    chk("rst_pix", bus.pixaddr, 32'd0);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    chk("rst_fd", 32'(bus.flip_done), 32'd0);
  endtask
  task automatic model_reset();
    n = 0;
    frame_reg = 32'h0;
    cur_base = 32'h0;
    last_pix = 32'h0;
  endtask
  task automatic model_check();
    int p, h, v;
    logic e_hs, e_vs, e_ven, e_fs, e_fd;
    e_hs = 1'b1; e_vs = 1'b1; e_ven = 1'b0; e_fs = 1'b0; e_fd = 1'b0;
    if (n > 0) begin
      p = n - 1;
      h = p % 8;
      v = (p / 8) % 6;
      e_fs = h == 0 && v == 0;
      if (e_fs) cur_base = frame_reg;
      e_ven = h < 4 && v < 3;
      if (e_ven) last_pix = cur_base + 32'(v * 16 + h);
      e_hs = !(h >= 5 && h < 7);
      e_vs = v != 4;
      e_fd = h == 0 && v == 4;
      if (e_fd) frame_reg = bus.fb_base;
    end
    chk("hs", 32'(bus.hs), 32'(e_hs));
    chk("vs", 32'(bus.vs), 32'(e_vs));
    chk("ven", 32'(bus.ven), 32'(e_ven));
    chk("pixaddr", bus.pixaddr, last_pix);
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    chk("flip_done", 32'(bus.flip_done), 32'(e_fd));
    n++;
  endtask
  initial begin
    bus.fb_base = 32'h0;
    repeat (3) @(negedge clk);
    reset_chk();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c < 96) bus.fb_base = 32'h0;
      else if (c < 192) bus.fb_base = 32'hFFFF_FFFE;
      else if ($urandom_range(0, 19) == 0)
        bus.fb_base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if (c == 1000 || (c > 300 && $urandom_range(0, 299) == 0)) begin
        #2 rst_n = 1'b0;
        #1 reset_chk();
        @(negedge clk);
        reset_chk();
        rst_n = 1'b1;
        model_reset();
      end
      @(posedge clk);
      #1 model_check();
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
